mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, meaning memory access latency in cycles (legal range 1..15).
REQ-002 SHALL have port clk  input  1  the single clock; every state element updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset; it is asynchronous and active-low.
REQ-004 SHALL have ports i_req  input  1  fetch request; i_addr  input  32  fetch address.
REQ-005 SHALL have ports i_rdata  output  32  fetched word; i_ready  output  1  fetch-complete pulse.
REQ-006 SHALL have ports d_req  input  1  data request; d_we  input  1  data write; d_addr  input  32  data address; d_wdata  input  32  store data.
REQ-007 SHALL have ports d_rdata  output  32  load data; d_ready  output  1  data-complete pulse.
REQ-008 SHALL have ports mem_en  output  1; mem_we  output  1; mem_addr  output  32; mem_wdata  output  32; mem_rdata  input  32 (the shared single-port memory).
REQ-009 SHALL have ports stall_f  output  1  fetch stall to the hazard unit; stall_m  output  1  memory-stage stall to the hazard unit.

Function
REQ-010 SHALL implement states IDLE, IBUSY, DBUSY, DONE.
REQ-011 In IDLE, d_req=1 SHALL move to DBUSY; else i_req=1 SHALL move to IBUSY; else stay in IDLE.
REQ-012 On a grant, the winner's address, d_we and d_wdata SHALL be registered; mem_addr/mem_we/mem_wdata SHALL drive the registered values and stay stable throughout BUSY.
REQ-013 mem_en SHALL be 1 in IBUSY/DBUSY only; mem_we SHALL be 1 only in DBUSY with a registered write.
REQ-014 A 4-bit counter SHALL load MEM_LAT-1 on grant and decrement each BUSY cycle; BUSY with counter 0 SHALL go to DONE.
REQ-015 On the BUSY->DONE edge, mem_rdata SHALL be captured into i_rdata (fetch) or d_rdata (data read); a write SHALL leave d_rdata unchanged.
REQ-016 In DONE, exactly the served side's ready SHALL be 1 for one cycle; requests SHALL be ignored in DONE; next state IDLE.
REQ-017 Request-to-ready latency SHALL be MEM_LAT+1 cycles when granted immediately from IDLE.
REQ-018 Requesters hold req and operands until ready; a req dropped mid-transaction SHALL NOT abort it (ready still pulses).
REQ-019 stall_f SHALL equal i_req & ~i_ready and stall_m SHALL equal d_req & ~d_ready, combinationally.
REQ-020 i_rdata/d_rdata SHALL hold their last value until the next capture for their side.

Reset
REQ-021 reset=0 SHALL immediately force state IDLE, counter 0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, i_ready=0, d_ready=0, i_rdata=0, d_rdata=0, last-grant flag=fetch.
REQ-022 Reset asserted mid-transaction SHALL abort it with no ready pulse; first grant is possible on the first clock edge after release.

Configuration
REQ-023 Macro ARB_ROUND_ROBIN_EN defined: when i_req and d_req are both 1 in IDLE, the side not served last SHALL be granted; a last-grant flag SHALL update on every grant.
REQ-024 Macro undefined: fixed data-over-fetch priority per REQ-011; no last-grant flag logic is built.

Verification
REQ-025 MEM_LAT=2, i_req=1 i_addr=0x8 alone, mem_rdata=0xE3A00005 -> IBUSY 2 cycles, i_ready=1 at cycle 3 with i_rdata=0xE3A00005; stall_f=1 cycles 0-2.
REQ-026 d_req=1 d_we=1 d_addr=0x40 d_wdata=0x1234 -> mem_en=mem_we=1, mem_addr=0x40 for 2 cycles, d_ready at cycle 3, d_rdata unchanged.
REQ-027 i_req and d_req both raised same cycle, fixed priority -> data served first (d_ready cycle 3), fetch granted cycle 4, i_ready cycle 7.
REQ-028 Same stimulus with ARB_ROUND_ROBIN_EN after reset (last=fetch) -> data first; second simultaneous pair -> fetch first.
REQ-029 reset pulsed low during DBUSY cycle 1 -> mem_en=0 immediately, no d_ready, state IDLE; after release a held d_req is re-granted.
REQ-030 MEM_LAT=1 read at d_addr=0x100 -> d_ready 2 cycles after d_req, d_rdata=mem_rdata value.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter: fetch/data arbiter for one shared single-port memory.        |
// | Optional ARB_ROUND_ROBIN_EN: alternate grants when both sides request.    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall_f,
  output logic        stall_m
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_IBUSY = 2'd1;
  localparam logic [1:0] c_DBUSY = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;
  localparam logic [3:0] c_LAT_LOAD = 4'(MEM_LAT - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_nextState;
  logic [3:0]  r_count;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic        r_servedData;
  logic        w_grantData;
  logic        w_grantFetch;
  logic        w_busy;
  logic        w_lastBusy;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_lastData;

  // On contention the side that was not served last wins.
  always_comb begin
    w_grantData  = 1'b0;
    w_grantFetch = 1'b0;
    if (r_state == c_IDLE) begin
      if (d_req && i_req) begin
        w_grantData  = ~r_lastData;
        w_grantFetch = r_lastData;
      end else begin
        w_grantData  = d_req;
        w_grantFetch = i_req;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lastData <= 1'b0;
    end else if (w_grantData || w_grantFetch) begin
      r_lastData <= w_grantData;
    end
  end
`else
  assign w_grantData  = (r_state == c_IDLE) && d_req;
  assign w_grantFetch = (r_state == c_IDLE) && i_req && !d_req;
`endif

  assign w_busy     = (r_state == c_IBUSY) || (r_state == c_DBUSY);
  assign w_lastBusy = w_busy && (r_count == 4'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_grantData) begin
          w_nextState = c_DBUSY;
        end else if (w_grantFetch) begin
          w_nextState = c_IBUSY;
        end
      end
      c_IBUSY, c_DBUSY: begin
        if (r_count == 4'd0) begin
          w_nextState = c_DONE;
        end
      end
      default: w_nextState = c_IDLE;
    endcase
  end

  always_comb begin
    mem_en  = w_busy;
    mem_we  = (r_state == c_DBUSY) && r_we;
    i_ready = (r_state == c_DONE) && !r_servedData;
    d_ready = (r_state == c_DONE) && r_servedData;
  end

  // Transaction operands are latched at grant so the memory side stays stable
  // even if the requester changes or drops its inputs mid-transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count      <= 4'd0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_we         <= 1'b0;
      r_servedData <= 1'b0;
      i_rdata      <= 32'd0;
      d_rdata      <= 32'd0;
    end else begin
      if (w_grantData) begin
        r_addr       <= d_addr;
        r_we         <= d_we;
        r_wdata      <= d_wdata;
        r_servedData <= 1'b1;
        r_count      <= c_LAT_LOAD;
      end else if (w_grantFetch) begin
        r_addr       <= i_addr;
        r_we         <= 1'b0;
        r_servedData <= 1'b0;
        r_count      <= c_LAT_LOAD;
      end else if (w_busy && (r_count != 4'd0)) begin
        r_count <= r_count - 4'd1;
      end

      if (w_lastBusy) begin
        if (!r_servedData) begin
          i_rdata <= mem_rdata;
        end else if (!r_we) begin
          d_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign stall_f   = i_req & ~i_ready;
  assign stall_m   = d_req & ~d_ready;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_arbiter: random requesters against a transaction-timing model.     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_mem_arbiter;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        iReq, iReady, dReq, dWe, dReady, memEn, memWe, stallF, stallM;
  logic [31:0] iAddr, iRdata, dAddr, dWdata, dRdata, memAddr, memWdata, memRdata;

  logic        i1Req, i1Ready, d1Req, d1We, d1Ready, mem1En, mem1We, stallF1, stallM1;
  logic [31:0] i1Addr, i1Rdata, d1Addr, d1Wdata, d1Rdata, mem1Addr, mem1Wdata, mem1Rdata;

  function automatic logic [31:0] hashWord(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hE3A00005;
  endfunction

  // Memory content is a fixed function of the address.
  assign memRdata  = hashWord(memAddr);
  assign mem1Rdata = hashWord(mem1Addr);

  mem_arbiter #(.MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .i_req(iReq), .i_addr(iAddr), .i_rdata(iRdata), .i_ready(iReady),
    .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata),
    .d_rdata(dRdata), .d_ready(dReady),
    .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
    .mem_rdata(memRdata), .stall_f(stallF), .stall_m(stallM)
  );

  mem_arbiter #(.MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset),
    .i_req(i1Req), .i_addr(i1Addr), .i_rdata(i1Rdata), .i_ready(i1Ready),
    .d_req(d1Req), .d_we(d1We), .d_addr(d1Addr), .d_wdata(d1Wdata),
    .d_rdata(d1Rdata), .d_ready(d1Ready),
    .mem_en(mem1En), .mem_we(mem1We), .mem_addr(mem1Addr), .mem_wdata(mem1Wdata),
    .mem_rdata(mem1Rdata), .stall_f(stallF1), .stall_m(stallM1)
  );

  int nChecks = 0;
  int nPass   = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Transaction-level model state
  int          cyc, busyStart, readyAt, freeAt, iDoneAt, dDoneAt;
  bit          active, tData, tWe, winData;
  logic [31:0] tAddr, tWdata, expI, expD;
  bit          iOut, dOut, iGranted, dGranted, iDrop, dDrop;
  bit          expIRdy, expDRdy, inBusy, seen;
`ifdef ARB_ROUND_ROBIN_EN
  bit          lastData;
`endif

  initial begin
    reset = 1'b1;
    {iReq, dReq, dWe, i1Req, d1Req, d1We} = '0;
    {iAddr, dAddr, dWdata, i1Addr, d1Addr, d1Wdata} = '0;
    #2 reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checkVal("rst_i_ready",   32'(iReady), 32'd0);
    checkVal("rst_d_ready",   32'(dReady), 32'd0);
    checkVal("rst_mem_en",    32'(memEn),  32'd0);
    checkVal("rst_mem_we",    32'(memWe),  32'd0);
    checkVal("rst_mem_addr",  memAddr,     32'd0);
    checkVal("rst_mem_wdata", memWdata,    32'd0);
    checkVal("rst_i_rdata",   iRdata,      32'd0);
    checkVal("rst_d_rdata",   dRdata,      32'd0);
    @(negedge clk);
    reset = 1'b1;

    cyc = 0; busyStart = 0; readyAt = -1; freeAt = 0; iDoneAt = 0; dDoneAt = 0;
    active = 0; tData = 0; tWe = 0; tAddr = 0; tWdata = 0; expI = 0; expD = 0;
    iOut = 0; dOut = 0; iGranted = 0; dGranted = 0; iDrop = 0; dDrop = 0;
`ifdef ARB_ROUND_ROBIN_EN
    lastData = 0;
`endif

    for (int n = 0; n < 1600; n++) begin
      if (active && cyc == readyAt && !(tData && tWe)) begin
        if (tData) expD = hashWord(tAddr);
        else       expI = hashWord(tAddr);
      end
      expIRdy = active && (cyc == readyAt) && !tData;
      expDRdy = active && (cyc == readyAt) && tData;
      inBusy  = active && (cyc >= busyStart) && (cyc < readyAt);
      checkVal("i_ready", 32'(iReady), 32'(expIRdy));
      checkVal("d_ready", 32'(dReady), 32'(expDRdy));
      checkVal("mem_en",  32'(memEn),  32'(inBusy));
      checkVal("mem_we",  32'(memWe),  32'(inBusy && tData && tWe));
      if (inBusy) begin
        checkVal("mem_addr", memAddr, tAddr);
        if (tData && tWe) checkVal("mem_wdata", memWdata, tWdata);
      end
      checkVal("i_rdata", iRdata, expI);
      checkVal("d_rdata", dRdata, expD);

      if (iOut && iGranted && iDoneAt < cyc) iOut = 0;
      if (dOut && dGranted && dDoneAt < cyc) dOut = 0;
      if (!iOut && n < 1500 && (n == 0 || $urandom_range(0, 2) == 0)) begin
        iOut = 1; iGranted = 0; iDrop = 0;
        iAddr = $urandom & 32'hFFFF_FFFC;
      end
      if (!dOut && n < 1500 && (n == 0 || $urandom_range(0, 2) == 0)) begin
        dOut = 1; dGranted = 0; dDrop = 0;
        dAddr = $urandom & 32'hFFFF_FFFC;
        dWe = 1'($urandom_range(0, 1));
        dWdata = $urandom;
      end
      if (iOut && iGranted && !iDrop && $urandom_range(0, 3) == 0) iDrop = 1;
      if (dOut && dGranted && !dDrop && $urandom_range(0, 3) == 0) dDrop = 1;
      iReq = iOut && !iDrop;
      dReq = dOut && !dDrop;
      #1;
      checkVal("stall_f", 32'(stallF), 32'(iReq && !expIRdy));
      checkVal("stall_m", 32'(stallM), 32'(dReq && !expDRdy));

      if (cyc >= freeAt && (iReq || dReq)) begin
        winData = dReq;
`ifdef ARB_ROUND_ROBIN_EN
        if (iReq && dReq) winData = !lastData;
        lastData = winData;
`endif
        active = 1; tData = winData;
        tAddr = winData ? dAddr : iAddr;
        tWe = winData && dWe;
        tWdata = dWdata;
        busyStart = cyc + 1; readyAt = cyc + LAT + 1; freeAt = readyAt + 1;
        if (winData) begin dGranted = 1; dDoneAt = readyAt; end
        else         begin iGranted = 1; iDoneAt = readyAt; end
      end
      @(posedge clk); #1;
      cyc++;
    end

    // Reset during a data read aborts it; the held request is re-granted.
    iReq = 0; dReq = 1; dWe = 0; dAddr = 32'h55;
    @(posedge clk); #1;
    checkVal("abort_pre_mem_en", 32'(memEn), 32'd1);
    reset = 1'b0; #1;
    checkVal("abort_mem_en",  32'(memEn),  32'd0);
    checkVal("abort_d_ready", 32'(dReady), 32'd0);
    @(negedge clk);
    checkVal("abort_no_ready", 32'(dReady), 32'd0);
    reset = 1'b1;
    seen = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (dReady) begin
        seen = 1;
        checkVal("regrant_latency", 32'(k), 32'(LAT + 1));
      end
    end
    if (!seen) checkVal("regrant_timeout", 32'd0, 32'd1);
    checkVal("regrant_d_rdata", dRdata, hashWord(32'h55));
    dReq = 0;

    // Single-cycle memory latency
    d1Req = 1; d1We = 0; d1Addr = 32'h100; #1;
    checkVal("lat1_stall_m", 32'(stallM1), 32'd1);
    seen = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        checkVal("lat1_mem_en",   32'(mem1En), 32'd1);
        checkVal("lat1_mem_addr", mem1Addr,    32'h100);
      end
      if (d1Ready) begin
        seen = 1;
        checkVal("lat1_latency", 32'(k), 32'd2);
      end
    end
    if (!seen) checkVal("lat1_timeout", 32'd0, 32'd1);
    checkVal("lat1_d_rdata", d1Rdata, hashWord(32'h100));
    checkVal("lat1_i_ready", 32'(i1Ready), 32'd0);
    d1Req = 0;
    @(posedge clk); #1;
    checkVal("lat1_pulse_end", 32'(d1Ready), 32'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
